// File: rtl/decode_pkg.sv
// Shared types for the decode stage.
//  - Major opcode constants (OP_LUI .. OP_AMO).
//  - op_e: one value per supported RV32I/M/A/Zicsr instruction, plus OP_ILLEGAL.
//    OP_ILLEGAL is encoded as zero so an all-zero record decodes as "nothing".
//  - fmt_e: instruction format, used to gate register fields and pick the immediate.
//  - dec_t: the decoded record carried through the queue.
//  - sext12: sign-extends a 12-bit immediate to 32 bits.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  typedef enum logic [6:0] {
    OP_ILLEGAL,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, FENCE_I, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    LR_W, SC_W, AMOSWAP_W, AMOADD_W, AMOXOR_W, AMOAND_W, AMOOR_W,
    AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W
  } op_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] raw;
    logic        writes_rd;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        csr_op;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/dec_core.sv
// Purely combinational RV32I(+M/A/Zicsr) decoder.
// Ports:
//  raw  in   32     raw instruction word
//  pc   in   32     PC of the instruction (copied into the record)
//  dec  out  dec_t  decoded record
// ENABLE_M / ENABLE_A: when 0 the corresponding extension encodings decode as illegal.
// Illegal words produce op=OP_ILLEGAL, illegal=1, every other field zero except pc/raw.
module dec_core
  import decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_A = 1'b1
) (
  input  logic [31:0] raw,
  input  logic [31:0] pc,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] f5;

  assign opc = raw[6:0];
  assign f3  = raw[14:12];
  assign f7  = raw[31:25];
  assign f5  = raw[31:27];

  op_e  op;
  fmt_e fmt;
  logic shamt_imm;

  // Instruction identification: anything not explicitly recognised stays OP_ILLEGAL.
  always_comb begin
    op        = OP_ILLEGAL;
    fmt       = FMT_R;
    shamt_imm = 1'b0;
    if (raw[1:0] == 2'b11) begin
      case (opc)
        OP_LUI: begin
          op  = LUI;
          fmt = FMT_U;
        end
        OP_AUIPC: begin
          op  = AUIPC;
          fmt = FMT_U;
        end
        OP_JAL: begin
          op  = JAL;
          fmt = FMT_J;
        end
        OP_JALR: begin
          fmt = FMT_I;
          if (f3 == 3'd0) op = JALR;
        end
        OP_BRANCH: begin
          fmt = FMT_B;
          case (f3)
            3'd0:    op = BEQ;
            3'd1:    op = BNE;
            3'd4:    op = BLT;
            3'd5:    op = BGE;
            3'd6:    op = BLTU;
            3'd7:    op = BGEU;
            default: op = OP_ILLEGAL;
          endcase
        end
        OP_LOAD: begin
          fmt = FMT_I;
          case (f3)
            3'd0:    op = LB;
            3'd1:    op = LH;
            3'd2:    op = LW;
            3'd4:    op = LBU;
            3'd5:    op = LHU;
            default: op = OP_ILLEGAL;
          endcase
        end
        OP_STORE: begin
          fmt = FMT_S;
          case (f3)
            3'd0:    op = SB;
            3'd1:    op = SH;
            3'd2:    op = SW;
            default: op = OP_ILLEGAL;
          endcase
        end
        OP_IMM: begin
          fmt = FMT_I;
          case (f3)
            3'd0: op = ADDI;
            3'd2: op = SLTI;
            3'd3: op = SLTIU;
            3'd4: op = XORI;
            3'd6: op = ORI;
            3'd7: op = ANDI;
            3'd1: begin
              shamt_imm = 1'b1;
              if (f7 == 7'b0000000) op = SLLI;
            end
            default: begin
              // funct3 = 101: the upper bits select logical vs arithmetic shift
              shamt_imm = 1'b1;
              if (f7 == 7'b0000000)      op = SRLI;
              else if (f7 == 7'b0100000) op = SRAI;
            end
          endcase
        end
        OP_REG: begin
          fmt = FMT_R;
          case (f7)
            7'b0000000: begin
              case (f3)
                3'd0:    op = ADD;
                3'd1:    op = SLL;
                3'd2:    op = SLT;
                3'd3:    op = SLTU;
                3'd4:    op = XOR;
                3'd5:    op = SRL;
                3'd6:    op = OR;
                default: op = AND;
              endcase
            end
            7'b0100000: begin
              if (f3 == 3'd0)      op = SUB;
              else if (f3 == 3'd5) op = SRA;
            end
            7'b0000001: begin
              if (ENABLE_M) begin
                case (f3)
                  3'd0:    op = MUL;
                  3'd1:    op = MULH;
                  3'd2:    op = MULHSU;
                  3'd3:    op = MULHU;
                  3'd4:    op = DIV;
                  3'd5:    op = DIVU;
                  3'd6:    op = REM;
                  default: op = REMU;
                endcase
              end
            end
            default: op = OP_ILLEGAL;
          endcase
        end
        OP_FENCE: begin
          fmt = FMT_I;
          if (f3 == 3'd0)      op = FENCE;
          else if (f3 == 3'd1) op = FENCE_I;
        end
        OP_SYSTEM: begin
          fmt = FMT_I;
          case (f3)
            3'd0: begin
              // Only the two environment calls are recognised in funct3=000
              if (raw[31:20] == 12'd0)      op = ECALL;
              else if (raw[31:20] == 12'd1) op = EBREAK;
            end
            3'd1:    op = CSRRW;
            3'd2:    op = CSRRS;
            3'd3:    op = CSRRC;
            3'd5:    op = CSRRWI;
            3'd6:    op = CSRRSI;
            3'd7:    op = CSRRCI;
            default: op = OP_ILLEGAL;
          endcase
        end
        OP_AMO: begin
          fmt = FMT_R;
          // aq/rl (bits 26:25) are ignored; only word-size AMOs exist in RV32A
          if (ENABLE_A && f3 == 3'b010) begin
            case (f5)
              5'b00010: if (raw[24:20] == 5'd0) op = LR_W;
              5'b00011: op = SC_W;
              5'b00001: op = AMOSWAP_W;
              5'b00000: op = AMOADD_W;
              5'b00100: op = AMOXOR_W;
              5'b01100: op = AMOAND_W;
              5'b01000: op = AMOOR_W;
              5'b10000: op = AMOMIN_W;
              5'b10100: op = AMOMAX_W;
              5'b11000: op = AMOMINU_W;
              5'b11100: op = AMOMAXU_W;
              default:  op = OP_ILLEGAL;
            endcase
          end
        end
        default: op = OP_ILLEGAL;
      endcase
    end
  end

  // Record assembly: field gating, immediate selection and side-effect flags.
  always_comb begin
    dec     = '0;
    dec.pc  = pc;
    dec.raw = raw;
    dec.op  = op;
    if (op == OP_ILLEGAL) begin
      dec.illegal = 1'b1;
    end else begin
      if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) dec.rd  = raw[11:7];
      if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) dec.rs1 = raw[19:15];
      if (fmt inside {FMT_R, FMT_S, FMT_B})        dec.rs2 = raw[24:20];

      case (fmt)
        FMT_I:   dec.imm = sext12(raw[31:20]);
        FMT_S:   dec.imm = sext12({raw[31:25], raw[11:7]});
        FMT_B:   dec.imm = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
        FMT_U:   dec.imm = {raw[31:12], 12'd0};
        FMT_J:   dec.imm = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
        default: dec.imm = 32'd0;
      endcase
      if (shamt_imm) dec.imm = {27'd0, raw[24:20]};

      dec.is_load   = (opc == OP_LOAD);
      dec.is_store  = (opc == OP_STORE);
      dec.is_branch = (opc == OP_BRANCH);
      dec.csr_op    = (opc == OP_SYSTEM) && (f3 != 3'd0);
      dec.writes_rd = (dec.rd != 5'd0) && !dec.is_branch && !dec.is_store &&
                      (opc != OP_FENCE) && !((opc == OP_SYSTEM) && (f3 == 3'd0));
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry in-order result FIFO.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  in_valid/in_ready     fetch handshake carrying in_pc/in_instr
//  flush                 discards every queued record (and any push that cycle)
//  out_valid/out_ready   execute handshake; out_dec is the oldest record
//  count                 number of occupied entries
// Words are decoded combinationally in the accept cycle and the record is stored.
// in_ready comes from the registered count only, so a full queue does not accept
// even when a pop happens in the same cycle.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_A = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output dec_t                   out_dec,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_t             mem [DEPTH];
  dec_t             dec_new;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  dec_core #(
    .ENABLE_M (ENABLE_M),
    .ENABLE_A (ENABLE_A)
  ) u_dec_core (
    .raw (in_instr),
    .pc  (in_pc),
    .dec (dec_new)
  );

  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_dec   = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is cleared on reset so out_dec reads all-zero afterwards.
  // A flush only rewinds the pointers; stale contents are never marked valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr_reg] <= dec_new;
    end
  end

endmodule
